// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding and default RAM window for the data RAM
// arbiter, the RAM model and the address decoder.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [15:0] RAM_BOUND_L = 16'h0200;
  localparam logic [15:0] RAM_BOUND_U = 16'h0400;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational two-way request picker.
// Build option RAM_ARB_RR_EN: when defined, conflicts alternate against the
// last winner; otherwise port 0 always wins.
module ram_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_idx,
  output logic any_req
);

  assign any_req = req0 | req1;

`ifdef RAM_ARB_RR_EN
  // On a conflict the port that did not win last time goes next.
  always_comb begin
    gnt_idx = req1;
    if (req0 && req1) gnt_idx = ~last;
  end
`else
  logic unused_last;
  assign unused_last = last;

  // Fixed priority: port 1 only wins when port 0 is idle.
  always_comb begin
    gnt_idx = ~req0 & req1;
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the data RAM port between the CPU (port 0) and a
// DMA/debug requester (port 1). Each access is a fixed IDLE/ACCESS/RESP
// sequence with range check and absolute-to-offset translation.
// Build option RAM_ARB_RR_EN: round-robin arbitration instead of port 0 priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter logic [15:0] BOUND_L = RAM_BOUND_L,
  parameter logic [15:0] BOUND_U = RAM_BOUND_U
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        bw0,
  input  logic        bw1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] rdata,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_Din,
  output logic        ram_RW,
  output logic        BW,
  input  logic [15:0] ram_out
);

  state_t      state;
  logic        port_q;
  logic        we_q;
  logic        bw_q;
  logic        in_range_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        rvalid0_q;
  logic        rvalid1_q;
  logic        err0_q;
  logic        err1_q;

  logic        last;
  logic        pick_idx;
  logic        any_req;

  logic        sel_we;
  logic        sel_bw;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic [15:0] eff_addr;
  logic        sel_in_range;

  ram_arb_pick u_pick (
    .req0    (req0),
    .req1    (req1),
    .last    (last),
    .gnt_idx (pick_idx),
    .any_req (any_req)
  );

`ifdef RAM_ARB_RR_EN
  // Last-winner register; resets to port 1 so the first conflict goes to port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last <= pick_idx;
    end
  end
`else
  assign last = 1'b0;
`endif

  assign sel_we    = pick_idx ? we1    : we0;
  assign sel_bw    = pick_idx ? bw1    : bw0;
  assign sel_addr  = pick_idx ? addr1  : addr0;
  assign sel_wdata = pick_idx ? wdata1 : wdata0;

  // Word accesses are always aligned; the range check uses the aligned address.
  assign eff_addr     = sel_bw ? sel_addr : {sel_addr[15:1], 1'b0};
  assign sel_in_range = (eff_addr >= BOUND_L) && (eff_addr < BOUND_U);

  // Transaction sequencer with registered grant, completion and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      bw_q       <= 1'b0;
      in_range_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata      <= '0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            port_q     <= pick_idx;
            we_q       <= sel_we;
            bw_q       <= sel_bw;
            addr_q     <= eff_addr;
            wdata_q    <= sel_wdata;
            in_range_q <= sel_in_range;
            gnt0       <= ~pick_idx;
            gnt1       <= pick_idx;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q && in_range_q) begin
            rdata <= bw_q ? {8'h00, ram_out[7:0]} : ram_out;
          end else begin
            rdata <= '0;
          end
          rvalid0_q <= ~port_q;
          rvalid1_q <= port_q;
          err0_q    <= ~port_q & ~in_range_q;
          err1_q    <= port_q & ~in_range_q;
          state     <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A reset landing in the RESP cycle abandons the completion as well.
  assign rvalid0 = rvalid0_q & ~rst;
  assign rvalid1 = rvalid1_q & ~rst;
  assign err0    = err0_q & ~rst;
  assign err1    = err1_q & ~rst;

  // RAM port is only driven during ACCESS; writes are blocked while in reset.
  always_comb begin
    ram_addr = '0;
    ram_Din  = '0;
    BW       = 1'b0;
    ram_RW   = 1'b0;
    if (state == ACCESS) begin
      ram_addr = addr_q - BOUND_L;
      ram_Din  = bw_q ? {8'h00, wdata_q[7:0]} : wdata_q;
      BW       = bw_q;
      ram_RW   = we_q & in_range_q & ~rst;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of the ram_arbiter transaction sequence,
// byte/word handling, range errors, arbitration and mid-transaction reset.
// Build option RAM_ARB_RR_EN selects the round-robin expectations.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, bw0, bw1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [15:0] rdata, ram_addr, ram_Din, ram_out;
  logic        ram_RW, BW;

  logic [7:0]  mem [0:1023] = '{default: 8'h00};

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .we0     (we0),
    .we1     (we1),
    .bw0     (bw0),
    .bw1     (bw1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1),
    .err0    (err0),
    .err1    (err1),
    .rdata   (rdata),
    .ram_addr(ram_addr),
    .ram_Din (ram_Din),
    .ram_RW  (ram_RW),
    .BW      (BW),
    .ram_out (ram_out)
  );

  // Byte-addressed RAM model: little-endian words, byte writes touch one byte.
  assign ram_out = {mem[ram_addr[9:0] + 10'd1], mem[ram_addr[9:0]]};

  always @(posedge clk) begin
    if (ram_RW) begin
      mem[ram_addr[9:0]] <= ram_Din[7:0];
      if (!BW) mem[ram_addr[9:0] + 10'd1] <= ram_Din[15:8];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One complete transaction on a single port, checked cycle by cycle.
  task automatic xact(input string tag, input logic p, input logic we, input logic bw,
                      input logic [15:0] a, input logic [15:0] wd,
                      input logic [15:0] exp_addr, input logic exp_rw,
                      input logic exp_err, input logic [15:0] exp_rdata);
    logic [15:0] exp_din;
    exp_din = bw ? {8'h00, wd[7:0]} : wd;
    @(negedge clk);
    if (p) begin
      req1 = 1'b1; we1 = we; bw1 = bw; addr1 = a; wdata1 = wd;
    end else begin
      req0 = 1'b1; we0 = we; bw0 = bw; addr0 = a; wdata0 = wd;
    end
    @(negedge clk);
    chk({tag, ".gnt"}, {14'd0, gnt1, gnt0}, p ? 16'd2 : 16'd1);
    chk({tag, ".ram_addr"}, ram_addr, exp_addr);
    chk({tag, ".ram_RW"}, {15'd0, ram_RW}, {15'd0, exp_rw});
    chk({tag, ".BW"}, {15'd0, BW}, {15'd0, bw});
    if (we) chk({tag, ".ram_Din"}, ram_Din, exp_din);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk({tag, ".rvalid"}, {14'd0, rvalid1, rvalid0}, p ? 16'd2 : 16'd1);
    chk({tag, ".err"}, {14'd0, err1, err0}, exp_err ? (p ? 16'd2 : 16'd1) : 16'd0);
    chk({tag, ".rdata"}, rdata, exp_rdata);
    chk({tag, ".ram_RW_resp"}, {15'd0, ram_RW}, 16'd0);
    @(negedge clk);
    chk({tag, ".idle"}, {12'd0, gnt0, gnt1, rvalid0, rvalid1}, 16'd0);
  endtask

  initial begin
    logic exp_g1;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; bw0 = 1'b0; bw1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);

    chk("reset.ctl", {8'd0, gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_RW, BW}, 16'd0);
    chk("reset.rdata", rdata, 16'd0);
    chk("reset.ram_addr", ram_addr, 16'd0);
    chk("reset.ram_Din", ram_Din, 16'd0);
    rst = 1'b0;

    // Word write then odd-address word read of the same word.
    xact("wr_word", 1'b0, 1'b1, 1'b0, 16'h0210, 16'hBEEF, 16'h0010, 1'b1, 1'b0, 16'h0000);
    chk("wr_word.mem_lo", {8'd0, mem[16]}, 16'h00EF);
    chk("wr_word.mem_hi", {8'd0, mem[17]}, 16'h00BE);
    xact("rd_word", 1'b0, 1'b0, 1'b0, 16'h0211, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'hBEEF);

    // Byte write into a pre-filled word leaves the neighbouring byte alone.
    xact("fill", 1'b1, 1'b1, 1'b0, 16'h0300, 16'h5AC3, 16'h0100, 1'b1, 1'b0, 16'h0000);
    xact("wr_byte", 1'b1, 1'b1, 1'b1, 16'h0301, 16'h12AB, 16'h0101, 1'b1, 1'b0, 16'h0000);
    chk("wr_byte.mem", {8'd0, mem[257]}, 16'h00AB);
    chk("wr_byte.neigh", {8'd0, mem[256]}, 16'h00C3);
    xact("rd_byte", 1'b1, 1'b0, 1'b1, 16'h0301, 16'h0000, 16'h0101, 1'b0, 1'b0, 16'h00AB);
    xact("rd_word2", 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000, 16'h0100, 1'b0, 1'b0, 16'hABC3);

    // Last in-range word and range errors on both sides of the window.
    xact("wr_top", 1'b0, 1'b1, 1'b0, 16'h03FE, 16'h1234, 16'h01FE, 1'b1, 1'b0, 16'h0000);
    xact("rd_top", 1'b1, 1'b0, 1'b1, 16'h03FF, 16'h0000, 16'h01FF, 1'b0, 1'b0, 16'h0012);
    xact("wr_oor", 1'b1, 1'b1, 1'b0, 16'h0400, 16'h7777, 16'h0200, 1'b0, 1'b1, 16'h0000);
    xact("rd_oor", 1'b1, 1'b0, 1'b0, 16'h01FE, 16'h0000, 16'hFFFE, 1'b0, 1'b1, 16'h0000);
    xact("rd_base", 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);

    // Both ports request continuously for four transactions.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; bw0 = 1'b0; addr0 = 16'h0210;
    req1 = 1'b1; we1 = 1'b0; bw1 = 1'b1; addr1 = 16'h0301;
    for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_RR_EN
      exp_g1 = (i % 2) == 1;
`else
      exp_g1 = 1'b0;
`endif
      @(negedge clk);
      chk($sformatf("conflict%0d.gnt", i), {14'd0, gnt1, gnt0}, exp_g1 ? 16'd2 : 16'd1);
      @(negedge clk);
      chk($sformatf("conflict%0d.rdata", i), rdata, exp_g1 ? 16'h00AB : 16'hBEEF);
      @(negedge clk);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during the ACCESS cycle of a write aborts it cleanly.
    req0 = 1'b1; we0 = 1'b1; bw0 = 1'b0; addr0 = 16'h0220; wdata0 = 16'h5555;
    @(negedge clk);
    chk("rst_acc.gnt", {15'd0, gnt0}, 16'd1);
    req0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_acc.ram_RW", {15'd0, ram_RW}, 16'd0);
    @(negedge clk);
    chk("rst_acc.ctl", {8'd0, gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_RW, BW}, 16'd0);
    chk("rst_acc.bus", ram_addr | ram_Din | rdata, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_acc.no_rvalid", {14'd0, rvalid0, err0}, 16'd0);
    chk("rst_acc.mem", {mem[33], mem[32]}, 16'h0000);

    // Normal service resumes after the abort.
    xact("post_rst", 1'b0, 1'b0, 1'b0, 16'h0210, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'hBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and access sequencer for the data RAM of the MSP430 model. It shares the single RAM port between the CPU (port 0) and a DMA/debug requester (port 1), and range-checks absolute addresses against the RAM window. It also translates those addresses to RAM offsets and drives the RAM's address, write-data, write-enable and byte/word controls. Every access is a fixed 3-cycle transaction with registered grant, read data and completion pulses.

## Interface
- BOUND_L, 16'h0200, lowest absolute RAM address (inclusive)
- BOUND_U, 16'h0400, upper absolute RAM bound (exclusive)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request; hold stable until matching gnt
- we0 / we1  in  1  1 = write, 0 = read
- bw0 / bw1  in  1  1 = byte, 0 = word (MSP430 BW semantics)
- addr0 / addr1  in  16  absolute byte address
- wdata0 / wdata1  in  16  write data (byte writes use [7:0])
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted
- rvalid0 / rvalid1  out  1  one-cycle pulse: transaction complete, rdata valid
- err0 / err1  out  1  one-cycle pulse with rvalid: address out of range
- rdata  out  16  read data for the completing port; 0 for writes and errors
- ram_addr  out  16  RAM offset
- ram_Din  out  16  RAM write data
- ram_RW  out  1  RAM write enable
- BW  out  1  RAM byte/word select
- ram_out  in  16  RAM combinational read data

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE:** if any req is high, pick a winner and latch its we/bw/addr/wdata and port id. Go to ACCESS. Otherwise stay in IDLE.
- **ACCESS:** present the latched access to the RAM. At the end of the cycle, capture the read result into rdata and go to RESP.
- **RESP:** pulse rvalid (and err if flagged) of the latched port. Return to IDLE.
- **Arbitration:** fixed priority, port 0 wins. Round-robin is available via the configuration macro.
- **Address translation:**
  - Word access: the address bit 0 is forced to 0.
  - ram_addr = latched addr − BOUND_L, truncated to 16 bits.
  - Out of range means addr < BOUND_L or addr ≥ BOUND_U. For an out-of-range access, ram_RW stays 0, rdata = 0 and err is set.
- **Write data:**
  - Word: ram_Din = wdata.
  - Byte: ram_Din = {8'h00, wdata[7:0]}.
- **Read data:**
  - Word: rdata = ram_out.
  - Byte: rdata = {8'h00, ram_out[7:0]}.
  - Write transactions: rdata = 0.
- **RAM control:**
  - ram_RW = (state == ACCESS) & we_q & in_range_q & ~rst. No RAM write can occur in a cycle where rst is high.
  - BW = bw_q during ACCESS, 0 otherwise.
  - ram_addr and ram_Din are 0 outside ACCESS.
- **Losing requester:** keeps req high. It is served in the next IDLE cycle.
- **Simultaneous req0 and req1:** exactly one gnt pulses. Both gnt signals are never high together.

## Timing
- Request sampled in IDLE at edge T.
- T+1: state is ACCESS, gnt pulses, RAM signals are driven and any write commits at the end of the cycle.
- T+2: state is RESP, rvalid/err pulse and rdata is valid.
- T+3: state is IDLE, the next request can be sampled.
- Throughput: one transaction per 3 cycles. A continuously held req gets back-to-back service every 3 cycles.
- rdata holds its value until the next RESP.
- Reset values: state is IDLE; all gnt/rvalid/err are 0; rdata, ram_addr, ram_Din, ram_RW and BW are 0; the round-robin pointer favours port 0.
- Reset during ACCESS or RESP: the transaction is abandoned with no write, no rvalid and no err. The requester must reissue it.

## Configuration
- RAM_ARB_RR_EN defined: round-robin arbitration. A 1-bit last-winner register is updated on each grant, and on a conflict the port that did not win last wins.
- RAM_ARB_RR_EN undefined: fixed priority, port 0 always wins. The last-winner register is not built. Port 1 can starve under continuous port 0 requests; this is intended.

## Structure
- Shared package ram_arb_pkg holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - default RAM_BOUND_L / RAM_BOUND_U constants, also used by the RAM and the address decoder
- Sub-module ram_arb_pick: combinational 2-way picker. Inputs are req0, req1 and last-winner; outputs are the grant index and any-request. It contains the RAM_ARB_RR_EN conditional.

## Test plan
- Reset, then a port 0 word write of 16'hBEEF to 16'h0210 → gnt0 at T+1, RAM offset 16'h0010 holds EF/BE, rvalid0 at T+2, rdata = 0.
- Port 0 word read of 16'h0211 (odd) → ram_addr = 16'h0010, rdata = 16'hBEEF, err0 = 0.
- Port 1 byte write of 16'h12AB to 16'h0301, then a byte read of the same address → offset 16'h0101 = AB, the neighbouring byte is unchanged, rdata = 16'h00AB.
- req0 and req1 both held high for 4 transactions → fixed priority: four gnt0 and no gnt1. With RAM_ARB_RR_EN: gnt0, gnt1, gnt0, gnt1.
- Port 1 write to 16'h0400 and read from 16'h01FE → ram_RW never high, err1 and rvalid1 pulse together, rdata = 0.
- rst asserted during the ACCESS cycle of a write to 16'h0220 → memory unchanged, no rvalid, all outputs 0 on the next cycle.
